// File: rtl/mux_pkg.sv
// Shared definitions for mux_rr_stream: mode constants, output-register state
// encoding and the rotate-priority pick used by the round-robin arbiter.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Largest supported channel count and its index width.
    localparam int MAX_N = 16;
    localparam int IDX_W = 4;
    localparam int CW    = IDX_W + 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit of req[0..n-1] at or after ptr, wrapping at n.
    // The loop runs downward so the smallest offset is the last writer and wins.
    function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                      input int               n,
                                      input logic [IDX_W-1:0] ptr);
        pick_t          p;
        logic [CW-1:0]  c;
        p = '0;
        for (int off = MAX_N - 1; off >= 0; off--) begin
            if (off < n) begin
                c = {1'b0, ptr} + CW'(off);
                if (c >= CW'(n)) c = c - CW'(n);
                if (req[c[IDX_W-1:0]]) begin
                    p.hit = 1'b1;
                    p.idx = c[IDX_W-1:0];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux_rr_stream_if.sv
// Stream bundle for mux_rr_stream: N input channels, one output channel and the
// select controls. y_par exists only when MUX_PARITY_EN is defined.
interface mux_rr_stream_if #(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int SW = $clog2(N)
) ();

    logic [N*W-1:0] i;
    logic [N-1:0]   i_valid;
    logic [N-1:0]   i_ready;
    logic           mode;
    logic [SW-1:0]  s;
    logic [W-1:0]   y;
    logic           y_valid;
    logic           y_ready;
    logic [SW-1:0]  y_ch;
`ifdef MUX_PARITY_EN
    logic           y_par;
`endif

    // The mux itself.
    modport slave (
        input  i, i_valid, mode, s, y_ready,
`ifdef MUX_PARITY_EN
        output y_par,
`endif
        output i_ready, y, y_valid, y_ch
    );

    // Producers, consumer and select control.
    modport master (
        output i, i_valid, mode, s, y_ready,
`ifdef MUX_PARITY_EN
        input  y_par,
`endif
        input  i_ready, y, y_valid, y_ch
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: one-hot grant plus encoded index of the
// first requester at or after ptr. The pointer register lives in the parent.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] idx
);

    pick_t w_pick;

    always_comb begin
        w_pick = rr_pick(MAX_N'(req), N, IDX_W'(ptr));
        gnt    = '0;
        idx    = '0;
        if (en && w_pick.hit) begin
            gnt = N'(1) << w_pick.idx;
            idx = SW'(w_pick.idx);
        end
    end

endmodule

// File: rtl/mux_rr_stream.sv
// N:1 valid/ready stream mux with fixed or round-robin selection and a single
// output register carrying the source channel. MUX_PARITY_EN adds y_par.
module mux_rr_stream
    import mux_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int SW = $clog2(N)
) (
    input logic            clk,
    input logic            rst_n,
    mux_rr_stream_if.slave bus
);

    state_t        r_state;
    logic [W-1:0]  r_y;
    logic [SW-1:0] r_ch;
    logic [SW-1:0] r_ptr;
`ifdef MUX_PARITY_EN
    logic          r_par;
`endif

    logic          w_load;
    logic          w_s_ok;
    logic          w_xfer;
    logic [N-1:0]  w_rr_gnt;
    logic [N-1:0]  w_fix_gnt;
    logic [N-1:0]  w_gnt;
    logic [SW-1:0] w_rr_idx;
    logic [SW-1:0] w_idx;
    logic [SW-1:0] w_ptr_nxt;
    logic [W-1:0]  w_data;

    assign w_load = (r_state == ST_EMPTY) || (bus.y_ready && (r_state == ST_FULL));

    rr_arbiter #(.N(N)) u_arb (
        .req (bus.i_valid),
        .ptr (r_ptr),
        .en  (w_load && (bus.mode == MODE_RR)),
        .gnt (w_rr_gnt),
        .idx (w_rr_idx)
    );

    // With a non power-of-two N, select codes past the last channel grant nothing.
    assign w_s_ok = (32'(bus.s) < N);

    always_comb begin
        w_fix_gnt = '0;
        if (w_load && (bus.mode == MODE_FIXED) && w_s_ok && bus.i_valid[bus.s])
            w_fix_gnt = N'(1) << bus.s;
    end

    assign w_gnt       = (bus.mode == MODE_RR) ? w_rr_gnt : w_fix_gnt;
    assign w_idx       = (bus.mode == MODE_RR) ? w_rr_idx : bus.s;
    assign w_xfer      = |w_gnt;
    assign bus.i_ready = w_gnt;
    assign w_ptr_nxt   = (32'(w_idx) == N - 1) ? '0 : w_idx + 1'b1;

    // AND-OR select on the one-hot grant keeps every index in range.
    always_comb begin
        w_data = '0;
        for (int k = 0; k < N; k++)
            if (w_gnt[k]) w_data = w_data | bus.i[k*W +: W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_y     <= '0;
            r_ch    <= '0;
            r_ptr   <= '0;
`ifdef MUX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_EMPTY: if (w_xfer) r_state <= ST_FULL;
                ST_FULL:  if (bus.y_ready && !w_xfer) r_state <= ST_EMPTY;
                default:  r_state <= ST_EMPTY;
            endcase
            if (w_xfer) begin
                r_y  <= w_data;
                r_ch <= w_idx;
`ifdef MUX_PARITY_EN
                r_par <= ^w_data;
`endif
                if (bus.mode == MODE_RR) r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign bus.y       = r_y;
    assign bus.y_valid = (r_state == ST_FULL);
    assign bus.y_ch    = r_ch;
`ifdef MUX_PARITY_EN
    assign bus.y_par   = r_par;
`endif

endmodule

// File: doc/mux_rr_stream.md
Name: mux_rr_stream

Overview:
- Parametrised N:1 stream multiplexer with valid/ready handshake on every input and on the output; generalises the 4:1 bit mux.
- Selection is either fixed (external select) or round-robin (internal arbitration).
- One output register stage; the selected channel number travels with the data.
- Sits between multiple producer channels and a single downstream consumer.

Parameters:
- N, 4, number of input channels (2..16).
- W, 8, data width per channel in bits (1..64).
- SW, $clog2(N), select/channel-index width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- i  in  N*W  packed channel data; channel k occupies i[k*W +: W].
- i_valid  in  N  per-channel valid.
- i_ready  out  N  per-channel ready; combinational.
- mode  in  1  0 = fixed select, 1 = round-robin.
- s  in  SW  channel select used when mode=0.
- y  out  W  registered output data.
- y_valid  out  1  output valid; registered.
- y_ready  in  1  downstream ready.
- y_ch  out  SW  channel index of the data in y; registered.

Behaviour:
- Reset (rst_n low, asynchronous): y=0, y_valid=0, y_ch=0, RR pointer ptr=0, state=EMPTY. Reset asserted mid-transfer discards held data; nothing is replayed after reset.
- States:
  - EMPTY: y_valid=0.
  - FULL: y_valid=1.
- load = (state==EMPTY) | (y_ready & y_valid). The output register accepts a new word only when load=1.
- Grant (combinational, computed only when load=1):
  - mode=0: grant channel s if i_valid[s]=1 and s<N. If s>=N (N not a power of two), there is no grant and no channel is ever readied.
  - mode=1: grant the first channel with i_valid set, searching ptr, ptr+1, ... mod N.
- i_ready[k] = load & (grant==k). At most one bit of i_ready is high. i_ready never depends on i_valid of other channels in mode=0.
- Transfer on a channel k when i_valid[k] & i_ready[k]:
  - Next edge: y = channel k data, y_ch = k, y_valid = 1.
  - In mode=1, ptr = (k+1) mod N. In mode=0, ptr is unchanged.
- Transitions:
  - EMPTY to FULL on a transfer.
  - FULL to EMPTY when y_ready=1 and there is no transfer.
  - FULL stays FULL on simultaneous drain and transfer (back-to-back, full throughput: one word per cycle).
  - FULL stays FULL with y, y_ch, y_valid held stable while y_ready=0.
- Latency: input handshake to y_valid is 1 cycle.
- Switching mode takes effect on the next grant evaluation. ptr is retained across mode changes.
- Round-robin fairness: with all N channels continuously valid and y_ready=1, grants rotate 0,1,...,N-1,0,... with no channel skipped.
- Every output is driven in every state; there are no X or Z values.

Optional Feature:
- Macro: MUX_PARITY_EN.
- Defined: adds output y_par (1 bit, registered alongside y). y_par = XOR of the accepted data word (even parity). Reset value is 0. It is held with y under backpressure.
- Undefined: the y_par port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package mux_pkg:
  - mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - state encoding ST_EMPTY and ST_FULL.
  - a rotate-priority helper function.
- Sub-module rr_arbiter, parametrised by N:
  - inputs: req[N], ptr, en.
  - outputs: one-hot gnt[N] and the encoded index.
  - combinational only; ptr stays in the parent.

Test Plan:
- Reset: rst_n low mid-stream with y_valid=1 → y=0, y_valid=0, y_ch=0 immediately (before any clock edge); after release, the first RR grant goes to channel 0.
- Fixed select, N=4, W=8, mode=0, s=2, i_valid=4'b1111, channel 2 data=8'hA5, y_ready=1 → i_ready=4'b0100; next cycle y=8'hA5, y_ch=2, y_valid=1.
- Round robin, mode=1, all valid, y_ready=1 for 8 cycles → y_ch sequence 0,1,2,3,0,1,2,3 with y_valid continuously 1.
- Backpressure: y_valid=1 with y=8'h3C and y_ready=0 for 5 cycles → i_ready=4'b0000, y stays 8'h3C, ptr unchanged; on release, the next word follows with no bubble.
- Sparse RR: ptr=1, i_valid=4'b1001 → grant channel 3, ptr becomes 0; next grant is channel 0.
- Parity (MUX_PARITY_EN defined): accept 8'h07 → y_par=1; accept 8'h03 → y_par=0.
